// File: rtl/spi_host_cmd_pkg.sv
// Command codes, FSM states and status-byte layout shared by the SPI host command slave.
package spi_host_cmd_pkg;

  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_CPU_RUN  = 8'h02;
  localparam logic [7:0] CMD_KEY      = 8'h03;
  localparam logic [7:0] CMD_WRITE    = 8'h04;
  localparam logic [7:0] CMD_STATUS   = 8'h05;
  localparam logic [7:0] CMD_CPU_HOLD = 8'h06;
  localparam logic [7:0] CMD_BANKHI   = 8'h07;
  localparam logic [7:0] CMD_READ     = 8'h08;

  // S_RBANK/S_RDATA are only reachable when the readback path is built.
  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_KEY_Y,
    S_KEY_X,
    S_BANK,
    S_DATA,
    S_BANKHI,
    S_STATUS,
    S_SINK,
    S_RBANK,
    S_RDATA
  } state_e;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_OVF      = 1;
  localparam int unsigned STAT_NONEMPTY = 2;

  function automatic logic [7:0] status_byte(input logic nonempty, input logic ovf,
                                             input logic busy);
    logic [7:0] s;
    s                = '0;
    s[STAT_BUSY]     = busy;
    s[STAT_OVF]      = ovf;
    s[STAT_NONEMPTY] = nonempty;
    return s;
  endfunction

endpackage

// File: rtl/spi_host_cmd_slave_if.sv
// Memory bus between the SPI command slave (master) and the SDRAM arbiter (slave).
// With SPI_READBACK_EN defined the bus also carries a read request and returned data.
interface spi_host_cmd_slave_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
`ifdef SPI_READBACK_EN
  logic              mem_rd_req;
  logic [7:0]        mem_rdata;
  logic              mem_rdata_en;

  modport master (
    output mem_wr_req, mem_addr, mem_wdata, mem_rd_req,
    input  mem_ack, mem_rdata, mem_rdata_en
  );
  modport slave (
    input  mem_wr_req, mem_addr, mem_wdata, mem_rd_req,
    output mem_ack, mem_rdata, mem_rdata_en
  );
`else
  modport master (
    output mem_wr_req, mem_addr, mem_wdata,
    input  mem_ack
  );
  modport slave (
    input  mem_wr_req, mem_addr, mem_wdata,
    output mem_ack
  );
`endif
endinterface

// File: rtl/spi_host_byte_shifter.sv
// SPI mode-3 byte shifter: pin synchronisers, edge detection, RX/TX shift registers.
// With SPI_READBACK_EN defined it also flags the first falling edge of each byte.
module spi_host_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte
`ifdef SPI_READBACK_EN
  ,
  output logic       first_fall
`endif
);

  logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic       cs_d1_q, sclk_d1_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic [6:0] tx_sr_q;
  logic       cs_n_s, sclk_rise, sclk_fall;

  assign cs_n_s    = cs_sync_q[1];
  assign cs_fall   = cs_d1_q & ~cs_n_s;
  assign cs_rise   = ~cs_d1_q & cs_n_s;
  assign sclk_rise = sclk_sync_q[1] & ~sclk_d1_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_d1_q;
`ifdef SPI_READBACK_EN
  assign first_fall = ~cs_n_s & sclk_fall & (bit_cnt_q == 3'd0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b11;
      mosi_sync_q <= 2'b00;
      cs_d1_q     <= 1'b1;
      sclk_d1_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '1;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      spi_miso    <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      cs_d1_q     <= cs_n_s;
      sclk_d1_q   <= sclk_sync_q[1];
      byte_valid  <= 1'b0;
      if (cs_n_s) begin
        // Deselected: any partial byte is dropped and MISO idles high.
        bit_cnt_q <= '0;
        spi_miso  <= 1'b1;
      end else begin
        if (sclk_rise) begin
          rx_sr_q   <= {rx_sr_q[5:0], mosi_sync_q[1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_valid <= 1'b1;
            rx_byte    <= {rx_sr_q, mosi_sync_q[1]};
          end
        end
        // The first falling edge of a byte keeps the pre-loaded MSB on the line.
        if (tx_load) begin
          spi_miso <= tx_byte[7];
          tx_sr_q  <= tx_byte[6:0];
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          spi_miso <= tx_sr_q[6];
          tx_sr_q  <= {tx_sr_q[5:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/spi_host_cmd_slave.sv
// SPI mode-3 command slave: key matrix, CPU reset, status and buffered SDRAM image writes.
// Define SPI_READBACK_EN to add the cmd 08 SDRAM readback path.
module spi_host_cmd_slave
  import spi_host_cmd_pkg::*;
#(
  parameter int unsigned KEY_ROWS     = 16,
  parameter int unsigned BANK_BITS    = 8,
  parameter int unsigned BANK_HI_BITS = 2,
  parameter int unsigned PAGE_BITS    = 14,
  parameter int unsigned WFIFO_DEPTH  = 2,
  parameter logic [7:0]  ID_BYTE      = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_cs_n,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  input  logic                    sdram_busy,
  spi_host_cmd_slave_if.master    mem,
  output logic [KEY_ROWS*8-1:0]   key_matrix,
  output logic                    cpu_reset
);

  localparam int unsigned ADDR_W = BANK_HI_BITS + BANK_BITS + PAGE_BITS;
  localparam int unsigned CNT_W  = $clog2(WFIFO_DEPTH + 1);
  localparam int unsigned IDX_W  = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;

  logic                    cs_fall, cs_rise, byte_valid;
  logic [7:0]              rx_byte;
  logic                    tx_load_q;
  logic [7:0]              tx_byte_q;
  state_e                  state_q;
  logic [BANK_BITS-1:0]    bank_q;
  logic [BANK_HI_BITS-1:0] bank_hi_q;
  logic [PAGE_BITS-1:0]    offset_q;
  logic [7:0]              key_y_q;
  logic                    overflow_q;

  logic [ADDR_W-1:0]       fifo_addr_q [WFIFO_DEPTH];
  logic [7:0]              fifo_data_q [WFIFO_DEPTH];
  logic [IDX_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic                    fifo_empty, fifo_full, push_req, push, pop;
  logic [ADDR_W-1:0]       push_addr;

`ifdef SPI_READBACK_EN
  logic                    first_fall;
  logic                    rd_pend_q, rd_wait_q, rd_req_q;
  logic [ADDR_W-1:0]       rd_addr_q;
`endif

  spi_host_byte_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_n   (spi_cs_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .tx_load    (tx_load_q),
    .tx_byte    (tx_byte_q),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
`ifdef SPI_READBACK_EN
    ,
    .first_fall (first_fall)
`endif
  );

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(WFIFO_DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(WFIFO_DEPTH));
  assign pop        = mem.mem_ack & ~fifo_empty;
  assign push_req   = byte_valid & (state_q == S_DATA);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push       = push_req & (~fifo_full | pop);
  assign push_addr  = {bank_hi_q, bank_q, offset_q};

  assign mem.mem_wr_req = ~fifo_empty;
  assign mem.mem_wdata  = fifo_data_q[rd_ptr_q];
`ifdef SPI_READBACK_EN
  assign mem.mem_addr   = fifo_empty ? rd_addr_q : fifo_addr_q[rd_ptr_q];
  assign mem.mem_rd_req = rd_req_q;
`else
  assign mem.mem_addr   = fifo_addr_q[rd_ptr_q];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < WFIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= push_addr;
        fifo_data_q[wr_ptr_q] <= rx_byte;
        wr_ptr_q              <= idx_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= idx_next(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      bank_hi_q  <= '0;
      offset_q   <= '0;
      key_y_q    <= '0;
      overflow_q <= 1'b0;
      key_matrix <= '1;
      cpu_reset  <= 1'b1;
      tx_load_q  <= 1'b0;
      tx_byte_q  <= ID_BYTE;
`ifdef SPI_READBACK_EN
      rd_pend_q  <= 1'b0;
      rd_wait_q  <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
`endif
    end else begin
      tx_load_q <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_req_q  <= 1'b0;
`endif
      if (cs_rise) begin
        state_q <= S_IDLE;
`ifdef SPI_READBACK_EN
        rd_pend_q <= 1'b0;
        rd_wait_q <= 1'b0;
`endif
      end else if (cs_fall) begin
        state_q   <= S_CMD;
        tx_load_q <= 1'b1;
        tx_byte_q <= ID_BYTE;
      end else if (byte_valid) begin
        tx_load_q <= 1'b1;
        tx_byte_q <= ID_BYTE;
        case (state_q)
          S_CMD: begin
            case (rx_byte)
              CMD_NOP:      state_q <= S_SINK;
              CMD_CPU_RUN:  begin cpu_reset <= 1'b0; state_q <= S_SINK; end
              CMD_CPU_HOLD: begin cpu_reset <= 1'b1; state_q <= S_SINK; end
              CMD_KEY:      state_q <= S_KEY_Y;
              CMD_WRITE:    state_q <= S_BANK;
              CMD_BANKHI:   state_q <= S_BANKHI;
              CMD_STATUS: begin
                state_q    <= S_STATUS;
                tx_byte_q  <= status_byte(~fifo_empty, overflow_q, sdram_busy);
                overflow_q <= 1'b0;
              end
`ifdef SPI_READBACK_EN
              CMD_READ:     state_q <= S_RBANK;
`else
              CMD_READ:     state_q <= S_SINK;
`endif
              default:      state_q <= S_SINK;
            endcase
          end
          S_KEY_Y: begin
            key_y_q <= rx_byte;
            state_q <= S_KEY_X;
          end
          S_KEY_X: begin
            // Rows at or beyond KEY_ROWS match no index and are ignored.
            for (int unsigned r = 0; r < KEY_ROWS; r++) begin
              if (key_y_q == 8'(r)) key_matrix[8*r +: 8] <= rx_byte;
            end
            state_q <= S_SINK;
          end
          S_BANK: begin
            bank_q   <= BANK_BITS'(rx_byte);
            offset_q <= '0;
            state_q  <= S_DATA;
          end
          S_DATA: begin
            offset_q <= offset_q + PAGE_BITS'(1);
            if (!push) overflow_q <= 1'b1;
          end
          S_BANKHI: begin
            bank_hi_q <= rx_byte[BANK_HI_BITS-1:0];
            state_q   <= S_SINK;
          end
`ifdef SPI_READBACK_EN
          S_RBANK: begin
            bank_q    <= BANK_BITS'(rx_byte);
            offset_q  <= '0;
            state_q   <= S_RDATA;
            tx_load_q <= 1'b0;
            rd_pend_q <= 1'b1;
            rd_wait_q <= 1'b1;
          end
          S_RDATA: begin
            tx_load_q <= 1'b0;
            rd_pend_q <= 1'b1;
            rd_wait_q <= 1'b1;
          end
`endif
          default: state_q <= S_SINK;
        endcase
      end
`ifdef SPI_READBACK_EN
      // Reads are held back until every buffered write has reached the arbiter.
      if (rd_pend_q && fifo_empty) begin
        rd_req_q  <= 1'b1;
        rd_addr_q <= {bank_hi_q, bank_q, offset_q};
        offset_q  <= offset_q + PAGE_BITS'(1);
        rd_pend_q <= 1'b0;
      end
      if (rd_wait_q && mem.mem_rdata_en) begin
        tx_load_q <= 1'b1;
        tx_byte_q <= mem.mem_rdata;
        rd_wait_q <= 1'b0;
      end else if (rd_wait_q && first_fall) begin
        tx_load_q  <= 1'b1;
        tx_byte_q  <= 8'hFF;
        overflow_q <= 1'b1;
        rd_wait_q  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/spi_host_cmd_slave.md
Name: spi_host_cmd_slave

Overview:
- SPI-mode-3 command slave through which the host MCU (Stamp-S3) controls the FPGA core.
- Functions: link check, key-matrix load, ROM/RAM image streaming into SDRAM, status polling, CPU reset control.
- Successor of the fixed step-6 command interface, now parametrised in key rows, bank width and write-buffer depth.
- Adds a buffered write path with overflow detection.
- Sits between the SPI pins and the SDRAM arbiter, keyboard matrix and CPU reset.

Parameters:
- KEY_ROWS, 16: key-matrix rows, each 8 bits.
- BANK_BITS, 8: bank byte width set by cmd 04.
- BANK_HI_BITS, 2: upper bank bits set by cmd 07.
- PAGE_BITS, 14: offset width; 16 KB page.
- WFIFO_DEPTH, 2: write buffer entries; power of two, ≥1.
- ID_BYTE, 8'hA5: idle/acknowledge response byte.

Ports:
- clk  in  1  system clock; must be ≥8× spi_clk.
- reset  in  1  asynchronous, active-high.
- spi_cs_n  in  1  chip select, active low.
- spi_clk  in  1  SPI clock; idle high.
- spi_mosi  in  1  master data.
- spi_miso  out  1  slave data.
- sdram_busy  in  1  SDRAM controller initialising.
- mem_wr_req  out  1  write request; held until mem_ack.
- mem_addr  out  BANK_HI_BITS+BANK_BITS+PAGE_BITS  byte address.
- mem_wdata  out  8  write data.
- mem_ack  in  1  one-cycle accept pulse.
- key_matrix  out  KEY_ROWS*8  row y = bits [8y+7:8y]; active-low keys.
- cpu_reset  out  1  CPU held in reset when 1.

Behaviour:
- Reset values:
  - spi_miso=1; mem_wr_req=0; mem_addr=0; mem_wdata=0.
  - key_matrix all 1s; cpu_reset=1.
  - bank, bank_hi, offset=0; FIFO empty; overflow=0; FSM=S_IDLE.
- Front end:
  - 2-FF synchronisers on cs_n, spi_clk, mosi.
  - Shift MSB-first on synchronised spi_clk rising edge.
  - MISO shifts out MSB-first on falling edge.
  - The MSB of the next response byte is driven on cs_n fall and after each byte completes.
- Byte complete = 8th rising edge; yields a one-clk byte_valid with the byte value.
- Response byte: ID_BYTE for every byte, except the byte after a cmd 05 byte, which returns the status byte.
  - Status = {5'b0, fifo_nonempty, overflow, sdram_busy}.
  - Loading the status byte clears overflow.
- FSM states: S_IDLE, S_CMD, S_KEY_Y, S_KEY_X, S_BANK, S_DATA, S_BANKHI, S_STATUS, S_SINK.
  - cs_n fall: S_IDLE→S_CMD.
  - 00: → S_SINK; NOP/ping.
  - 02: cpu_reset←0, → S_SINK.
  - 06: cpu_reset←1, → S_SINK.
  - 03: → S_KEY_Y → S_KEY_X; row y←x if y<KEY_ROWS, else ignored; → S_SINK.
  - 04: → S_BANK; bank←byte, offset←0; → S_DATA.
  - 05: → S_STATUS → S_SINK.
  - 07: → S_BANKHI; bank_hi←byte[BANK_HI_BITS-1:0]; → S_SINK.
  - Unknown codes: → S_SINK.
- S_DATA: each byte pushes {bank_hi, bank, offset, byte} into the FIFO, then offset+1.
  - Offset wraps 2^PAGE_BITS-1 → 0 within the same bank.
  - Push when FIFO full: byte dropped, overflow←1, offset still increments.
- FIFO head drives mem_wr_req/addr/wdata. Pop on mem_ack.
  - Push and pop in the same cycle when full is legal; no overflow.
- cs_n rise at any time:
  - Partial byte discarded; FSM→S_IDLE; spi_miso←1.
  - FIFO continues draining. cpu_reset, key_matrix and bank registers retained.
- Reset mid-transfer flushes the FIFO and drops mem_wr_req immediately.

Optional Feature:
- SPI_READBACK_EN defined:
  - Adds ports mem_rd_req out 1, mem_rdata in 8, mem_rdata_en in 1.
  - Adds cmd 08: bank byte, then dummy bytes.
  - After each byte boundary in S_RDATA, issues a read at offset and increments offset.
  - The next response byte = mem_rdata if mem_rdata_en arrived before the next byte's first falling edge; else 8'hFF and overflow←1.
  - Reads wait until the FIFO is empty.
- Undefined: cmd 08 is treated as unknown; those ports are absent.

Decomposition:
- Package spi_host_cmd_pkg:
  - Command code localparams (CMD_NOP=00, CMD_CPU_RUN=02, CMD_KEY=03, CMD_WRITE=04, CMD_STATUS=05, CMD_CPU_HOLD=06, CMD_BANKHI=07, CMD_READ=08).
  - State enum; status bit indices.
- Sub-module spi_host_byte_shifter: synchronisers, edge detect, RX/TX shift, byte_valid, tx load.

Test Plan:
- Ping: cs low, send 00 → MISO byte 0xA5; cpu_reset stays 1.
- Key load: 03,05,7F → key_matrix[47:40]=8'h7F, other rows FF. Then 03,10,00 (y=16) → no change.
- Status: sdram_busy=1, send 05,00 → second byte 0x01. With busy=0 → 0x00.
- Write stream: 07,01 then 04,82 then 3 bytes 11,22,33 with mem_ack after 2 clk → writes addr {2'b01,8'h82,14'h0000..0002} with data 11,22,33 in order.
- Wrap/overflow: write 16385 bytes → last byte at offset 0. Then hold mem_ack=0 and send 3 bytes with WFIFO_DEPTH=2 → 3rd dropped; status=0x06, next status read 0x04.
- Abort: cs_n high after 4 bits of a 04 data byte → no write issued. 00 ping then returns A5; cpu_reset after 02 → 0.
